// File: rtl/hazard_scoreboard.sv
// D-stage GPR Tuse/Tnew stall unit with a cycle-exact HI/LO (mult/div) busy counter.
// Optional macro HAZ_STATS_EN adds a saturating stall-cycle counter on stall_cnt.
module hazard_scoreboard #(
    parameter int AW      = 5,
    parameter int TW      = 2,
    parameter int NSTG    = 3,
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs_d,
    input  logic [AW-1:0] rt_d,
    input  logic [TW-1:0] tuse_rs_d,
    input  logic [TW-1:0] tuse_rt_d,
    input  logic [AW-1:0] a3_d,
    input  logic          we_d,
    input  logic [TW-1:0] tnew_d,
    input  logic          md_start_d,
    input  logic          md_div_d,
    input  logic          md_use_d,
    output logic          stall,
    output logic          stall_data,
    output logic          stall_md,
    output logic          md_busy,
    output logic [31:0]   stall_cnt
);
    localparam int CW = $clog2(DIV_CYC + 1);
    localparam logic [TW-1:0] TUSE_NONE = '1;

    logic [NSTG-1:0]         rec_valid_q, rec_valid_d;
    logic [NSTG-1:0]         rec_we_q, rec_we_d;
    logic [NSTG-1:0][AW-1:0] rec_a3_q, rec_a3_d;
    logic [NSTG-1:0][TW-1:0] rec_tnew_q, rec_tnew_d;
    logic [CW-1:0]           md_cnt_q, md_cnt_d;
    logic                    hit_rs, hit_rt;

    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        for (int k = 0; k < NSTG; k++) begin
            if (rec_valid_q[k] && rec_we_q[k] && (rec_a3_q[k] != '0)) begin
                if ((rec_a3_q[k] == rs_d) && (tuse_rs_d != TUSE_NONE) &&
                    (rec_tnew_q[k] > tuse_rs_d))
                    hit_rs = 1'b1;
                if ((rec_a3_q[k] == rt_d) && (tuse_rt_d != TUSE_NONE) &&
                    (rec_tnew_q[k] > tuse_rt_d))
                    hit_rt = 1'b1;
            end
        end
    end

    assign stall_data = hit_rs | hit_rt;
    assign md_busy    = (md_cnt_q != '0);
    assign stall_md   = md_use_d & md_busy;
    assign stall      = stall_data | stall_md;

    // A stalled D instruction becomes a bubble in E; older entries age with saturating tnew.
    always_comb begin
        rec_valid_d = '0;
        rec_we_d    = '0;
        rec_a3_d    = '0;
        rec_tnew_d  = '0;
        if (!stall) begin
            rec_valid_d[0] = 1'b1;
            rec_we_d[0]    = we_d;
            rec_a3_d[0]    = a3_d;
            rec_tnew_d[0]  = tnew_d;
        end
        for (int k = 1; k < NSTG; k++) begin
            rec_valid_d[k] = rec_valid_q[k-1];
            rec_we_d[k]    = rec_we_q[k-1];
            rec_a3_d[k]    = rec_a3_q[k-1];
            rec_tnew_d[k]  = (rec_tnew_q[k-1] == '0) ? '0 : rec_tnew_q[k-1] - TW'(1);
        end
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start_d && !stall)
            md_cnt_d = md_div_d ? CW'(DIV_CYC) : CW'(MUL_CYC);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rec_valid_q <= '0;
            rec_we_q    <= '0;
            rec_a3_q    <= '0;
            rec_tnew_q  <= '0;
            md_cnt_q    <= '0;
        end else begin
            rec_valid_q <= rec_valid_d;
            rec_we_q    <= rec_we_d;
            rec_a3_q    <= rec_a3_d;
            rec_tnew_q  <= rec_tnew_d;
            md_cnt_q    <= md_cnt_d;
        end
    end

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= 32'd0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
